// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with bus handshake, timeout and MEM/WB register
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regwritem,
  input  logic        memtoregm,
  input  logic        memwritem,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  input  logic [4:0]  writeregm,
  input  logic [31:0] pcplus4m,
  input  logic        jumplinkm,
  input  logic [1:0]  memsizem,
  input  logic        memsignedm,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stallm,
  output logic        regwritew,
  output logic        memtoregw,
  output logic        jumplinkw,
  output logic [31:0] aluoutw,
  output logic [31:0] readdataw,
  output logic [31:0] pcplus4w,
  output logic [4:0]  writeregw,
  output logic        misalignw,
  output logic        buserrw
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic [1:0] a;
  logic is_byte, is_half, memop, misaligned, timeout, buserr, ld_done;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [31:0] ld_fmt;
  assign a = aluoutm[1:0];
  assign is_byte = memsizem == 2'b00;
  assign is_half = memsizem == 2'b01;
  assign memop = memtoregm | memwritem;
  assign misaligned = is_half ? a[0] : (!is_byte && a != 2'b00);
  assign dmem_req = rst_n & memop & ~misaligned;
  assign dmem_we = memwritem & dmem_req;
  assign dmem_addr = {aluoutm[31:2], 2'b00};
  assign dmem_wdata = is_byte ? {4{writedatam[7:0]}} : is_half ? {2{writedatam[15:0]}} : writedatam;
  assign dmem_be = !dmem_req ? 4'b0000 : is_byte ? 4'b0001 << a : is_half ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign timeout = wait_cnt == 8'(TIMEOUT - 1);
  assign buserr = timeout & ~dmem_ready;
  assign ld_done = memtoregm & dmem_req & dmem_ready;
  assign lb = dmem_rdata[{a, 3'b000} +: 8];
  assign lh = dmem_rdata[{a[1], 4'b0000} +: 16];
  assign ld_fmt = is_byte ? {{24{memsignedm & lb[7]}}, lb} : is_half ? {{16{memsignedm & lh[15]}}, lh} : dmem_rdata;
  // FSM state and wait counter register; reset abandons any pending access
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end
  // Next state: enter WAIT on an unanswered request, leave on ready or timeout
  always_comb begin
    state_nx = state == IDLE ? ((dmem_req & ~dmem_ready) ? WAIT : IDLE) : (stallm ? WAIT : IDLE);
  end
  // FSM outputs: stall while waiting short of timeout, count cycles spent in WAIT
  always_comb begin
    stallm = dmem_req & ~dmem_ready & ~timeout;
    wait_cnt_nx = state_nx == WAIT ? wait_cnt + 8'd1 : 8'd0;
  end
  // MEM/WB register: bubble on stall (data held), otherwise capture the completed instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {regwritew, memtoregw, jumplinkw, misalignw, buserrw} <= 5'b0;
      aluoutw <= 32'd0;
      readdataw <= 32'd0;
      pcplus4w <= 32'd0;
      writeregw <= 5'd0;
    end else if (stallm) begin
      {regwritew, memtoregw, jumplinkw, misalignw, buserrw} <= 5'b0;
    end else begin
      regwritew <= regwritem & ~(memop & misaligned) & ~buserr;
      memtoregw <= memtoregm;
      jumplinkw <= jumplinkm;
      misalignw <= memop & misaligned;
      buserrw <= buserr;
      aluoutw <= aluoutm;
      readdataw <= ld_done ? ld_fmt : 32'd0;
      pcplus4w <= pcplus4m;
      writeregw <= writeregm;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized self-checking bench against a transaction-level reference model
module tb_mem_stage_lsu;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0;
  logic regwritem = 0, memtoregm = 0, memwritem = 0, jumplinkm = 0, memsignedm = 0, dmem_ready = 0;
  logic [31:0] aluoutm = 0, writedatam = 0, pcplus4m = 0, dmem_rdata = 0;
  logic [4:0] writeregm = 0;
  logic [1:0] memsizem = 0;
  logic dmem_req, dmem_we, stallm, regwritew, memtoregw, jumplinkw, misalignw, buserrw;
  logic [31:0] dmem_addr, dmem_wdata, aluoutw, readdataw, pcplus4w;
  logic [3:0] dmem_be;
  logic [4:0] writeregw;
  int checks = 0, failures = 0;
  logic [31:0] p_alu = 0;
  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .regwritem(regwritem), .memtoregm(memtoregm), .memwritem(memwritem),
    .aluoutm(aluoutm), .writedatam(writedatam), .writeregm(writeregm), .pcplus4m(pcplus4m),
    .jumplinkm(jumplinkm), .memsizem(memsizem), .memsignedm(memsignedm), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stallm(stallm), .regwritew(regwritew),
    .memtoregw(memtoregw), .jumplinkw(jumplinkw), .aluoutw(aluoutw), .readdataw(readdataw),
    .pcplus4w(pcplus4w), .writeregw(writeregw), .misalignw(misalignw), .buserrw(buserrw)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // One instruction: delay = cycles until dmem_ready pulses (large = never)
  task automatic run(input logic rw, input logic mr, input logic mw, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [4:0] wr, input logic [31:0] pc,
                     input logic jl, input logic [1:0] sz, input logic sg, input int delay,
                     input logic [31:0] rd);
    int nb, off, k, stalls, stall_e;
    logic mis, req, byready, berr;
    logic [31:0] mask, v, exp_rd, exp_wd;
    logic [3:0] be;
    nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    off = int'(addr[1:0]);
    mis = (mr | mw) && (off % nb != 0);
    req = (mr | mw) && !mis;
    stall_e = !req ? 0 : (delay < TO - 1 ? delay : TO - 1);
    byready = req && delay <= TO - 1;
    berr = req && !byready;
    mask = nb == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
    v = (rd >> (8 * off)) & mask;
    if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
    exp_rd = (mr && byready) ? v : 32'h0;
    exp_wd = nb == 1 ? {4{wd[7:0]}} : nb == 2 ? {2{wd[15:0]}} : wd;
    be = req ? 4'(((1 << nb) - 1) << off) : 4'h0;
    @(negedge clk);
    {regwritem, memtoregm, memwritem, jumplinkm, memsignedm} = {rw, mr, mw, jl, sg};
    aluoutm = addr; writedatam = wd; writeregm = wr; pcplus4m = pc; memsizem = sz;
    dmem_rdata = rd; dmem_ready = delay == 0;
    #1;
    chk("req", dmem_req, req);
    chk("we", dmem_we, req && mw);
    chk("be", dmem_be, be);
    chk("addr", dmem_addr, {addr[31:2], 2'b00});
    if (req && mw) chk("wdata", dmem_wdata, exp_wd);
    stalls = 0; k = 0;
    while (stallm) begin
      stalls++;
      @(posedge clk); #1;
      chk("bubble", {27'b0, regwritew, memtoregw, jumplinkw, misalignw, buserrw}, 32'h0);
      chk("hold_alu", aluoutw, p_alu);
      @(negedge clk);
      k++;
      dmem_ready = k == delay;
      #1;
      if (k > 300) begin
        chk("stall_bound", k, stall_e);
        break;
      end
    end
    chk("stalls", stalls, stall_e);
    @(posedge clk); #1;
    chk("regwritew", regwritew, rw && !mis && !berr);
    chk("memtoregw", memtoregw, mr);
    chk("jumplinkw", jumplinkw, jl);
    chk("misalignw", misalignw, mis);
    chk("buserrw", buserrw, berr);
    chk("aluoutw", aluoutw, addr);
    chk("readdataw", readdataw, exp_rd);
    chk("writeregw", writeregw, wr);
    chk("pcplus4w", pcplus4w, pc);
    p_alu = addr;
  endtask
  initial begin
    int op, dsel;
    logic [31:0] ad;
    memtoregm = 1; aluoutm = 32'h100; memsizem = 2'd2; regwritem = 1;
    @(negedge clk); #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stallm, 0);
    @(posedge clk); #1;
    chk("rst_ctl", {27'b0, regwritew, memtoregw, jumplinkw, misalignw, buserrw}, 0);
    chk("rst_data", aluoutw | readdataw | pcplus4w | 32'(writeregw), 0);
    rst_n = 1;
    run(1, 0, 0, 32'h1234, 0, 5, 32'h40, 0, 2, 0, 1000, 0);
    run(1, 1, 0, 32'h103, 0, 7, 32'h44, 0, 0, 1, 0, 32'h80FF_7F01);
    run(1, 1, 0, 32'h103, 0, 8, 32'h48, 0, 0, 0, 0, 32'h80FF_7F01);
    run(0, 0, 1, 32'h202, 32'hABCD_1234, 0, 32'h4C, 0, 1, 0, 3, 0);
    run(1, 1, 0, 32'h101, 0, 9, 32'h50, 0, 2, 0, 0, 32'h1111_2222);
    run(1, 1, 0, 32'h104, 0, 10, 32'h54, 0, 2, 0, 1000, 32'h3333_4444);
    run(1, 1, 0, 32'h108, 0, 11, 32'h58, 0, 1, 1, TO - 1, 32'h5555_9876);
    run(1, 0, 0, 32'h5C, 0, 31, 32'h60, 1, 2, 0, 1000, 0);
    @(negedge clk);
    {regwritem, memtoregm, memwritem, jumplinkm} = 4'b1100;
    aluoutm = 32'h300; memsizem = 2'd2; dmem_ready = 0;
    @(posedge clk); @(negedge clk); @(posedge clk);
    @(negedge clk); rst_n = 0; #1;
    chk("rstw_req", dmem_req, 0);
    chk("rstw_stall", stallm, 0);
    @(posedge clk); #1;
    chk("rstw_ctl", {27'b0, regwritew, memtoregw, jumplinkw, misalignw, buserrw}, 0);
    chk("rstw_data", aluoutw | readdataw | pcplus4w | 32'(writeregw), 0);
    rst_n = 1; p_alu = 0;
    run(1, 1, 0, 32'h300, 0, 12, 32'h64, 0, 2, 0, 0, 32'hCAFE_F00D);
    for (int i = 0; i < 50; i++) begin
      op = $urandom_range(0, 2);
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
      dsel = $urandom_range(0, 9);
      run(1'($urandom), op == 1, op == 2, ad, $urandom, 5'($urandom), $urandom, 1'($urandom),
          2'($urandom), 1'($urandom), dsel < 7 ? dsel % 5 : dsel == 7 ? TO - 2 : dsel == 8 ? TO - 1 : 1000,
          $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
